i2s_serializer: RTL and testbench
=================================

# i2s_serializer

Transmit end of the I2S audio path: takes processed stereo samples (after the effects stage) through a valid/ready handshake and serializes them as standard Philips I2S, generating SCLK and LRCK from the system clock. It is the bus master toward the DAC. It mirrors the receive-side deserializer so the effect blocks stay purely parallel.

## Interface
- DATA_WIDTH, 24: sample width in bits, 1..31.
- CLK_PER_BIT, 4: clk cycles per SCLK period; even, ≥ 2.
- clk  input  1  system/audio master clock.
- rst  input  1  asynchronous, active-high reset.
- tx_data_l  input  DATA_WIDTH  left sample, two's complement.
- tx_data_r  input  DATA_WIDTH  right sample, two's complement.
- tx_valid  input  1  stereo pair on tx_data_l/tx_data_r is valid.
- tx_ready  output  1  holding register empty; pair is accepted when tx_valid && tx_ready.
- underrun  output  1  one-clk pulse: frame started with holding register empty.
- sclk  output  1  I2S bit clock, registered.
- lrck  output  1  I2S word select, registered; 0 = left, 1 = right.
- sdata  output  1  I2S serial data, registered.

## Operation
- Divider div_cnt counts 0..CLK_PER_BIT-1 and wraps; sclk = 1 when div_cnt ≥ CLK_PER_BIT/2, else 0.
- "Tick" = clk cycle where div_cnt wraps (SCLK falling edge). On each tick bit_cnt (6 bits, 0..63) increments and wraps 63→0; lrck and sdata update only on ticks.
- Frame = 64 SCLK: slot bits 0..31 left (lrck=0), 32..63 right (lrck=1). lrck = bit_cnt[5].
- Per slot bit k: k=0 → 0; k=1..DATA_WIDTH → sample MSB..LSB; k>DATA_WIDTH → 0 (one-SCLK I2S delay, zero pad).
- Holding register: one stereo pair plus full flag; tx_ready = ~full. Accept sets full.
- Frame load on the tick where bit_cnt wraps 63→0: if full, copy holding to shift registers (left, right) and clear full; else pulse underrun and load per Configuration.
- Same-cycle accept and load with holding empty: counts as underrun for this frame; accepted pair stays held for the next frame.
- No accept possible on load cycle with holding full (tx_ready=0).

## Timing
- Reset values: sclk=0, lrck=0, sdata=0, tx_ready=1, underrun=0, div_cnt=0, bit_cnt=0, shift registers and last-sample registers 0.
- First frame after reset transmits zeros; first load occurs at the 64th tick (64·CLK_PER_BIT clk after rst release).
- Latency: pair accepted during frame N appears in frame N+1; left MSB on sdata one SCLK after lrck falls, right MSB one SCLK after lrck rises.
- sdata/lrck change only in the clk cycle after a tick (SCLK falling); stable across every SCLK rising edge.
- tx_ready rises the clk after load; underrun is high exactly one clk, coincident with load.
- rst mid-frame: all state returns to reset values immediately; pending held pair discarded.

## Configuration
- I2S_SER_HOLD_LAST_EN defined: on underrun, re-transmit the last successfully loaded pair (zero if none since reset).
- Not defined: on underrun, transmit zero for both channels.
- underrun pulses identically in both builds.

## Test plan
- Reset then idle (tx_valid=0), CLK_PER_BIT=4: sclk period 4 clk, lrck period 256 clk, sdata=0 throughout, underrun pulses every 256 clk.
- Send L=24'hA5A5A5, R=24'h5A5A5A in frame 0: frame 1 slot bits 1..24 left = A5A5A5 MSB first, right = 5A5A5A; bits 0 and 25..31 zero; tx_ready drops on accept, rises after load.
- Back-to-back: tx_valid held with new pairs each frame (L=N, R=~N): every frame carries its own pair, no underrun, exactly one accept per frame.
- Underrun after L=24'h800001, R=24'h7FFFFE: next frame repeats them with HOLD_LAST_EN, transmits zeros without; underrun pulses once.
- Accept in same clk as load with holding empty: underrun pulses, pair appears in the following frame.
- Assert rst mid-right-slot with pair held: outputs return to 0, tx_ready=1, held pair never transmitted.

Source files
------------

// File: rtl/i2s_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : i2s_serializer                                             |
// | Description : Philips I2S transmitter. Accepts stereo pairs through a    |
// |               valid/ready handshake into a one-pair holding register and |
// |               serializes them MSB first, one SCLK after each LRCK edge,  |
// |               generating SCLK/LRCK from clk (bus master toward the DAC). |
// |               Optional build macro I2S_SER_HOLD_LAST_EN: on underrun,    |
// |               re-send the last loaded pair instead of zeros.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module i2s_serializer #(
  parameter int DATA_WIDTH  = 24,
  parameter int CLK_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data_l,
  input  logic [DATA_WIDTH-1:0] tx_data_r,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  underrun,
  output logic                  sclk,
  output logic                  lrck,
  output logic                  sdata
);

  localparam int              DIV_W    = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_BIT - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_PER_BIT / 2);
  localparam logic [5:0]       DW6      = 6'(DATA_WIDTH);

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [5:0]            bit_cnt_q, bit_cnt_d;
  logic                  sclk_q, sclk_d;
  logic                  lrck_q, lrck_d;
  logic                  sdata_q, sdata_d;
  logic                  underrun_q, underrun_d;
  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DATA_WIDTH-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
`ifdef I2S_SER_HOLD_LAST_EN
  logic [DATA_WIDTH-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
`endif

  logic       tick;
  logic       load;
  logic       accept;
  logic [4:0] slot_bit;
  logic       in_data;

  // Next-state: clock divider, slot counter, holding register and shifters.
  always_comb begin
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    lrck_d     = lrck_q;
    sdata_d    = sdata_q;
    full_d     = full_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    shift_l_d  = shift_l_q;
    shift_r_d  = shift_r_q;
`ifdef I2S_SER_HOLD_LAST_EN
    last_l_d   = last_l_q;
    last_r_d   = last_r_q;
`endif

    tick     = (div_cnt_q == DIV_LAST);
    load     = tick && (bit_cnt_q == 6'd63);
    accept   = tx_valid && !full_q;
    slot_bit = 5'd0;
    in_data  = 1'b0;

    div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
    sclk_d     = (div_cnt_d >= DIV_HALF);
    underrun_d = load && !full_q;

    // An accept on an empty-holding load cycle stays held for the next frame.
    if (accept) begin
      hold_l_d = tx_data_l;
      hold_r_d = tx_data_r;
      full_d   = 1'b1;
    end

    if (tick) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
      lrck_d    = bit_cnt_d[5];
      slot_bit  = bit_cnt_d[4:0];
      in_data   = (slot_bit != 5'd0) && ({1'b0, slot_bit} <= DW6);
      sdata_d   = 1'b0;
      if (load) begin
        if (full_q) begin
          shift_l_d = hold_l_q;
          shift_r_d = hold_r_q;
          full_d    = 1'b0;
`ifdef I2S_SER_HOLD_LAST_EN
          last_l_d  = hold_l_q;
          last_r_d  = hold_r_q;
`endif
        end else begin
`ifdef I2S_SER_HOLD_LAST_EN
          shift_l_d = last_l_q;
          shift_r_d = last_r_q;
`else
          shift_l_d = '0;
          shift_r_d = '0;
`endif
        end
      end else if (in_data) begin
        if (bit_cnt_d[5]) begin
          sdata_d   = shift_r_q[DATA_WIDTH-1];
          shift_r_d = shift_r_q << 1;
        end else begin
          sdata_d   = shift_l_q[DATA_WIDTH-1];
          shift_l_d = shift_l_q << 1;
        end
      end
    end
  end

  // State register; reset returns everything to idle and drops any held pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      full_q     <= 1'b0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      shift_l_q  <= '0;
      shift_r_q  <= '0;
`ifdef I2S_SER_HOLD_LAST_EN
      last_l_q   <= '0;
      last_r_q   <= '0;
`endif
    end else begin
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= sclk_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      full_q     <= full_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      shift_l_q  <= shift_l_d;
      shift_r_q  <= shift_r_d;
`ifdef I2S_SER_HOLD_LAST_EN
      last_l_q   <= last_l_d;
      last_r_q   <= last_r_d;
`endif
    end
  end

  assign tx_ready = !full_q;
  assign underrun = underrun_q;
  assign sclk     = sclk_q;
  assign lrck     = lrck_q;
  assign sdata    = sdata_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_i2s_serializer                                          |
// | Description : Scoreboard bench for i2s_serializer. Stimulus pushes each   |
// |               accepted pair tagged with the frame it must appear in; a   |
// |               monitor decodes the I2S stream frame by frame and compares.|
// |               Honours I2S_SER_HOLD_LAST_EN for the underrun fill value.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_i2s_serializer;

  localparam int DW    = 24;
  localparam int CPB   = 4;
  localparam int FRAME = 64 * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] tx_data_l, tx_data_r;
  logic          tx_valid;
  logic          tx_ready, underrun, sclk, lrck, sdata;

  i2s_serializer #(.DATA_WIDTH(DW), .CLK_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data_l (tx_data_l),
    .tx_data_r (tx_data_r),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .underrun  (underrun),
    .sclk      (sclk),
    .lrck      (lrck),
    .sdata     (sdata)
  );

  always #5 clk = ~clk;

  // Rising clk edges since reset release; frame f owns loads at edge f*FRAME.
  int edges;
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  typedef struct {
    int            frame;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  pair_t sbq[$];
  int    vectors = 0;
  int    fails   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- monitor / reference model ----------------
  logic          bits [64];
  int            pos;
  int            mon_frame;
  logic          prev_sclk, prev_ur, ur_seen;
  logic [DW-1:0] last_l, last_r;

  task automatic check_frame();
    logic [DW-1:0] got_l, got_r, exp_l, exp_r;
    logic          pad, exp_ur;
    got_l = '0;
    got_r = '0;
    for (int k = 1; k <= DW; k++) begin
      got_l = {got_l[DW-2:0], bits[k]};
      got_r = {got_r[DW-2:0], bits[32 + k]};
    end
    pad = bits[0] | bits[32];
    for (int k = DW + 1; k < 32; k++) pad = pad | bits[k] | bits[32 + k];

    exp_l  = '0;
    exp_r  = '0;
    exp_ur = 1'b0;
    if (mon_frame > 0) begin
      while (sbq.size() > 0 && sbq[0].frame < mon_frame) begin
        chk("sb_stale_frame", 64'(sbq[0].frame), 64'(mon_frame));
        void'(sbq.pop_front());
      end
      if (sbq.size() > 0 && sbq[0].frame == mon_frame) begin
        exp_l  = sbq[0].l;
        exp_r  = sbq[0].r;
        last_l = exp_l;
        last_r = exp_r;
        void'(sbq.pop_front());
      end else begin
        exp_ur = 1'b1;
`ifdef I2S_SER_HOLD_LAST_EN
        exp_l  = last_l;
        exp_r  = last_r;
`endif
      end
    end
    chk("frame_left",    64'(got_l), 64'(exp_l));
    chk("frame_right",   64'(got_r), 64'(exp_r));
    chk("frame_padding", 64'(pad), 64'(0));
    chk("frame_underrun", 64'(ur_seen), 64'(exp_ur));
    ur_seen = 1'b0;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      pos       = 0;
      mon_frame = 0;
      prev_sclk = 1'b0;
      prev_ur   = 1'b0;
      ur_seen   = 1'b0;
      last_l    = '0;
      last_r    = '0;
    end else begin
      chk("sclk_phase", 64'(sclk), 64'((edges % CPB) >= (CPB / 2)));
      if (underrun) begin
        if (prev_ur) chk("underrun_width", 64'(1), 64'(0));
        ur_seen = 1'b1;
      end
      prev_ur = underrun;
      if (!prev_sclk && sclk) begin
        chk("lrck_slot", 64'(lrck), 64'(pos >= 32));
        bits[pos] = sdata;
        pos++;
        if (pos == 64) begin
          check_frame();
          pos = 0;
          mon_frame++;
        end
      end
      prev_sclk = sclk;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_until(input int e);
    int n = 0;
    while (edges != e && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (edges != e) chk("wait_until_timeout", 64'(edges), 64'(e));
  endtask

  // Offer one pair; the accept edge is the next rising edge after a negedge
  // where valid and ready are both high.
  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    pair_t p;
    int    n = 0;
    tx_data_l = l;
    tx_data_r = r;
    tx_valid  = 1'b1;
    while (!tx_ready && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      chk("send_timeout", 64'(0), 64'(1));
    end else begin
      p.frame = (edges + 1) / FRAME + 1;
      p.l     = l;
      p.r     = r;
      sbq.push_back(p);
      @(negedge clk);
      chk("ready_after_accept", 64'(tx_ready), 64'(0));
    end
    tx_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    rst       = 1'b1;
    tx_valid  = 1'b0;
    tx_data_l = '0;
    tx_data_r = '0;
    repeat (3) @(negedge clk);
    chk("rst_sclk",     64'(sclk),     64'(0));
    chk("rst_lrck",     64'(lrck),     64'(0));
    chk("rst_sdata",    64'(sdata),    64'(0));
    chk("rst_tx_ready", 64'(tx_ready), 64'(1));
    chk("rst_underrun", 64'(underrun), 64'(0));
    rst = 1'b0;

    // Directed pair in frame 0 -> frame 1.
    wait_until(20);
    send(24'hA5A5A5, 24'h5A5A5A);

    // Back-to-back: valid effectively held, one accept per frame.
    wait_until(FRAME + 30);
    for (int i = 1; i <= 5; i++) begin
      v = 24'(i * 24'h010203);
      send(v, ~v);
    end
    // Pair followed by idle frames exercises the underrun fill.
    send(24'h800001, 24'h7FFFFE);

    // Accept on the very edge of a load with holding empty.
    wait_until(10 * FRAME - 1);
    send(24'h123456, 24'hFEDCBA);

    // Random traffic, sometimes skipping frames.
    for (int f = 12; f < 20; f++) begin
      if ($urandom_range(0, 2) != 0) begin
        wait_until(f * FRAME + int'($urandom_range(1, 240)));
        send(24'($urandom()), 24'($urandom()));
      end
    end

    // Reset in the right slot with a pair held: it must never be sent.
    wait_until(21 * FRAME + 10);
    send(24'hDEADBE, 24'hBEEF01);
    wait_until(21 * FRAME + 160);
    rst = 1'b1;
    #1;
    chk("midrst_sclk",     64'(sclk),     64'(0));
    chk("midrst_lrck",     64'(lrck),     64'(0));
    chk("midrst_sdata",    64'(sdata),    64'(0));
    chk("midrst_tx_ready", 64'(tx_ready), 64'(1));
    repeat (3) @(negedge clk);
    sbq.delete();
    rst = 1'b0;

    wait_until(3 * FRAME + 10);
    chk("sb_drained", 64'(sbq.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
